// File: rtl/usb_eth_pkg.sv
// rtl/usb_eth_pkg.sv - shared state encodings, constants and helpers for the USB-Ethernet bridge
package usb_eth_pkg;

  localparam int unsigned LEN_HDR_BYTES = 2;
  localparam int unsigned DROP_CNT_W    = 16;

  localparam logic [6:0] ONEHOT_IDLE    = 7'b0000001;
  localparam logic [6:0] ONEHOT_CAPTURE = 7'b0000010;
  localparam logic [6:0] ONEHOT_HDR_H   = 7'b0000100;
  localparam logic [6:0] ONEHOT_HDR_L   = 7'b0001000;
  localparam logic [6:0] ONEHOT_RD      = 7'b0010000;
  localparam logic [6:0] ONEHOT_WR      = 7'b0100000;
  localparam logic [6:0] ONEHOT_DONE    = 7'b1000000;

  typedef enum logic [6:0] {
    S_IDLE    = ONEHOT_IDLE,
    S_CAPTURE = ONEHOT_CAPTURE,
    S_HDR_H   = ONEHOT_HDR_H,
    S_HDR_L   = ONEHOT_HDR_L,
    S_RD      = ONEHOT_RD,
    S_WR      = ONEHOT_WR,
    S_DONE    = ONEHOT_DONE
  } rx_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_rx_frame_buf.sv
// rtl/eth_rx_frame_buf.sv - simple dual-port byte RAM, one write port, one registered read port
module eth_rx_frame_buf #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // Write port: store one byte per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: data appears one cycle after the address.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_usb_ctrl.sv
// rtl/eth_rx_usb_ctrl.sv - captures one Ethernet RX frame and drains it to the USB write FIFO (optional length header: ETH_RX_LEN_HDR_EN)
module eth_rx_usb_ctrl
  import usb_eth_pkg::*;
#(
  parameter int BUF_DEPTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_pulse,
  input  logic                  rx_over,
  input  logic                  wrfifo_full,
  output logic [7:0]            wrfifo_data,
  output logic                  wrfifo_req,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] frame_drop_cnt
);

  localparam logic [15:0] DEPTH_CNT = 16'(BUF_DEPTH);

`ifdef ETH_RX_LEN_HDR_EN
  localparam rx_state_t DRAIN_START = S_HDR_H;
`else
  localparam rx_state_t DRAIN_START = S_RD;
`endif

  rx_state_t             state, state_n;
  logic [15:0]           wr_cnt, wr_cnt_n;
  logic [15:0]           rd_cnt, rd_cnt_n;
  logic [15:0]           len, len_n;
  logic                  ovf, ovf_n;
  logic                  discard, discard_n;
  logic [DROP_CNT_W-1:0] drop_n;
  logic                  req_n;
  logic [7:0]            data_n;

  logic [15:0]           cnt_eff;
  logic                  ovf_eff;
  logic                  buf_we;
  logic [7:0]            rd_data;

  eth_rx_frame_buf #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt[ADDR_W-1:0]),
    .wdata (rx_data),
    .raddr (rd_cnt[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  // A frame is held or being drained whenever we are past capture.
  assign busy = (state != S_IDLE) && (state != S_CAPTURE);

  // State register plus all datapath registers; outputs are registered so
  // wrfifo_req only follows an edge at which wrfifo_full was low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      len            <= '0;
      ovf            <= 1'b0;
      discard        <= 1'b0;
      frame_drop_cnt <= '0;
      wrfifo_req     <= 1'b0;
      wrfifo_data    <= '0;
    end else begin
      state          <= state_n;
      wr_cnt         <= wr_cnt_n;
      rd_cnt         <= rd_cnt_n;
      len            <= len_n;
      ovf            <= ovf_n;
      discard        <= discard_n;
      frame_drop_cnt <= drop_n;
      wrfifo_req     <= req_n;
      wrfifo_data    <= data_n;
    end
  end

  // Next-state, capture/discard bookkeeping and drain sequencing.
  always_comb begin
    state_n   = state;
    wr_cnt_n  = wr_cnt;
    rd_cnt_n  = rd_cnt;
    len_n     = len;
    ovf_n     = ovf;
    discard_n = discard;
    drop_n    = frame_drop_cnt;
    req_n     = 1'b0;
    data_n    = wrfifo_data;
    buf_we    = 1'b0;
    cnt_eff   = wr_cnt;
    ovf_eff   = ovf;

    if (busy || (state == S_IDLE && discard)) begin
      // A frame that starts while we cannot accept it is swallowed whole;
      // the flag blocks a new capture from starting mid-frame.
      if (rx_over && (discard || rx_pulse)) begin
        discard_n = 1'b0;
        drop_n    = sat_inc(frame_drop_cnt);
      end else if (rx_pulse) begin
        discard_n = 1'b1;
      end
    end else begin
      if (rx_pulse) begin
        state_n = S_CAPTURE;
        if (wr_cnt != DEPTH_CNT) begin
          buf_we  = 1'b1;
          cnt_eff = wr_cnt + 16'd1;
        end else begin
          ovf_eff = 1'b1;
        end
      end
      wr_cnt_n = cnt_eff;
      ovf_n    = ovf_eff;
      if (rx_over) begin
        if (ovf_eff) begin
          drop_n   = sat_inc(frame_drop_cnt);
          wr_cnt_n = '0;
          ovf_n    = 1'b0;
          state_n  = S_IDLE;
        end else if (cnt_eff == 16'd0) begin
          state_n = S_IDLE;
        end else begin
          len_n   = cnt_eff;
          state_n = DRAIN_START;
        end
      end
    end

    unique case (state)
      S_IDLE, S_CAPTURE: ;
`ifdef ETH_RX_LEN_HDR_EN
      S_HDR_H: begin
        if (!wrfifo_full) begin
          req_n   = 1'b1;
          data_n  = len[15:8];
          state_n = S_HDR_L;
        end
      end
      S_HDR_L: begin
        if (!wrfifo_full) begin
          req_n   = 1'b1;
          data_n  = len[7:0];
          state_n = S_RD;
        end
      end
`endif
      S_RD: state_n = S_WR;
      S_WR: begin
        if (!wrfifo_full) begin
          req_n    = 1'b1;
          data_n   = rd_data;
          rd_cnt_n = rd_cnt + 16'd1;
          state_n  = (rd_cnt + 16'd1 == len) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        wr_cnt_n = '0;
        rd_cnt_n = '0;
        len_n    = '0;
        ovf_n    = 1'b0;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_rx_usb_ctrl.sv
// tb/tb_eth_rx_usb_ctrl.sv - scoreboard bench for eth_rx_usb_ctrl (honours ETH_RX_LEN_HDR_EN)
module tb_eth_rx_usb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_pulse = 1'b0;
  logic        rx_over = 1'b0;
  logic        wrfifo_full = 1'b0;
  logic [7:0]  wrfifo_data;
  logic        wrfifo_req;
  logic        busy;
  logic [15:0] frame_drop_cnt;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int hold_reqs = 0;
  bit in_hold = 1'b0;
  int exp_drop = 0;
  logic full_at_edge;
  logic [7:0] exp_q[$];
  logic [7:0] frm[$];

`ifdef ETH_RX_LEN_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  always #5 clk = ~clk;

  eth_rx_usb_ctrl #(.BUF_DEPTH(2048), .ADDR_W(11)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_pulse       (rx_pulse),
    .rx_over        (rx_over),
    .wrfifo_full    (wrfifo_full),
    .wrfifo_data    (wrfifo_data),
    .wrfifo_req     (wrfifo_req),
    .busy           (busy),
    .frame_drop_cnt (frame_drop_cnt)
  );

  // Monitor: every write strobe pops the scoreboard and is compared.
  always @(posedge clk) begin
    logic [7:0] want;
    full_at_edge = wrfifo_full;
    #1;
    if (wrfifo_req) begin
      if (in_hold) hold_reqs++;
      checks++;
      if (full_at_edge) begin
        errors++;
        $display("FAIL req_after_full: req=1 while full was 1 at the edge");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: got %02h, expected no write", wrfifo_data);
      end else begin
        want = exp_q.pop_front();
        if (wrfifo_data !== want) begin
          errors++;
          $display("FAIL wr_byte[%0d]: got %02h, expected %02h", popped, wrfifo_data, want);
        end
      end
      popped++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push_expected();
    logic [15:0] n16;
    n16 = 16'(frm.size());
    if (HDR != 0) begin
      exp_q.push_back(n16[15:8]);
      exp_q.push_back(n16[7:0]);
    end
    foreach (frm[i]) exp_q.push_back(frm[i]);
  endtask

  task automatic send_frame(input bit coincide);
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      rx_pulse = 1'b1;
      rx_data  = frm[i];
      rx_over  = coincide && (i == frm.size() - 1);
    end
    if (!coincide) begin
      @(negedge clk);
      rx_pulse = 1'b0;
      rx_over  = 1'b1;
    end
    @(negedge clk);
    rx_pulse = 1'b0;
    rx_over  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 10000) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes outstanding, busy=%0b", name, exp_q.size(), busy);
    end
  endtask

  task automatic wait_pops(input int target, input string name);
    int n;
    n = 0;
    while (popped < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_timeout: popped %0d, needed %0d", name, popped, target);
    end
  endtask

  task automatic load4();
    frm = '{8'h11, 8'h22, 8'h33, 8'h44};
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("reset_req", wrfifo_req, 0);
    check("reset_data", wrfifo_data, 0);
    check("reset_busy", busy, 0);
    check("reset_drop", frame_drop_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 4-byte frame.
    load4();
    push_expected();
    send_frame(1'b0);
    wait_idle("basic");
    check("basic_pops", popped, HDR + 4);
    check("basic_busy", busy, 0);
    check("basic_drop", frame_drop_cnt, 0);

    // Same frame with the FIFO full for 10 cycles after byte 22.
    base = popped;
    load4();
    push_expected();
    send_frame(1'b0);
    wait_pops(base + HDR + 2, "hold_pre");
    @(negedge clk);
    wrfifo_full = 1'b1;
    in_hold = 1'b1;
    repeat (10) @(negedge clk);
    in_hold = 1'b0;
    wrfifo_full = 1'b0;
    check("hold_no_reqs", hold_reqs, 0);
    wait_idle("hold");
    check("hold_pops", popped - base, HDR + 4);

    // Second frame arrives during drain and is discarded; third is captured.
    base = popped;
    load4();
    push_expected();
    send_frame(1'b0);
    frm = '{8'hA1, 8'hA2, 8'hA3};
    send_frame(1'b0);
    exp_drop++;
    wait_idle("busy_drop");
    check("busy_drop_pops", popped - base, HDR + 4);
    check("busy_drop_cnt", frame_drop_cnt, exp_drop);
    base = popped;
    frm = '{8'h77, 8'h88, 8'h99};
    push_expected();
    send_frame(1'b0);
    wait_idle("third");
    check("third_pops", popped - base, HDR + 3);
    check("third_drop", frame_drop_cnt, exp_drop);

    // Oversize frame is dropped; a frame of exactly the buffer depth is kept.
    base = popped;
    frm.delete();
    for (int i = 0; i < 2049; i++) frm.push_back(8'(i * 7));
    send_frame(1'b0);
    exp_drop++;
    repeat (5) @(negedge clk);
    check("ovf_pops", popped - base, 0);
    check("ovf_drop", frame_drop_cnt, exp_drop);
    check("ovf_busy", busy, 0);
    frm.delete();
    for (int i = 0; i < 2048; i++) frm.push_back(8'(i + 3));
    push_expected();
    send_frame(1'b0);
    wait_idle("full_depth");
    check("full_depth_pops", popped - base, HDR + 2048);
    check("full_depth_drop", frame_drop_cnt, exp_drop);

    // Lone rx_over, then a byte coincident with rx_over.
    base = popped;
    @(negedge clk);
    rx_over = 1'b1;
    @(negedge clk);
    rx_over = 1'b0;
    repeat (5) @(negedge clk);
    check("lone_over_pops", popped - base, 0);
    check("lone_over_drop", frame_drop_cnt, exp_drop);
    check("lone_over_busy", busy, 0);
    frm = '{8'hAB};
    push_expected();
    send_frame(1'b1);
    wait_idle("coincide");
    check("coincide_pops", popped - base, HDR + 1);

    // Reset in the middle of a drain, then a 1-byte frame.
    base = popped;
    load4();
    push_expected();
    send_frame(1'b0);
    wait_pops(base + HDR + 2, "mid_rst_pre");
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_req", wrfifo_req, 0);
    check("rst_data", wrfifo_data, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", frame_drop_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_quiet_pops", popped - base, HDR + 2);
    base = popped;
    frm = '{8'h5A};
    push_expected();
    send_frame(1'b0);
    wait_idle("post_rst");
    check("post_rst_pops", popped - base, HDR + 1);
    check("post_rst_drop", frame_drop_cnt, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_usb_ctrl.md
Name: eth_rx_usb_ctrl

Overview:
- Return path of the USB-Ethernet bridge. Captures one received Ethernet payload, delivered as byte pulses with an end-of-frame strobe, into an internal frame buffer.
- Once the frame closes, drains the frame byte-by-byte into the USB write FIFO, honouring its full flag.
- Sits between the Ethernet receive parser and the USB TX FIFO.

Parameters:
- BUF_DEPTH, 2048, frame buffer depth in bytes (≥ largest accepted frame); power of two.
- ADDR_W, 11, log2(BUF_DEPTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- rx_data  input  8  received payload byte, valid when rx_pulse=1
- rx_pulse  input  1  one-cycle byte strobe
- rx_over  input  1  one-cycle end-of-frame strobe (may coincide with final rx_pulse)
- wrfifo_full  input  1  USB FIFO almost-full (asserts with ≥1 free entry margin)
- wrfifo_data  output  8  byte to USB FIFO
- wrfifo_req  output  1  one-cycle write strobe, data valid same cycle
- busy  output  1  high outside IDLE/CAPTURE (frame held or draining)
- frame_drop_cnt  output  16  saturating count of discarded frames

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low on clk/rst_n.
- Reset values: all outputs 0, byte count 0, discard flag 0, state IDLE.
- Reset mid-drain aborts the frame; the remaining bytes are lost.
- CAPTURE:
  - Each rx_pulse writes rx_data at address wr_cnt, then increments wr_cnt (16-bit).
  - IDLE moves to CAPTURE on the first rx_pulse.
- Close on rx_over:
  - A byte arriving in the same cycle as rx_over is included.
  - If wr_cnt = 0: no output, no drop; stay/return IDLE.
  - If overflow flag is set: drop the frame, frame_drop_cnt+1, go to IDLE.
  - Otherwise: latch len = wr_cnt, go to DRAIN.
- Overflow: an rx_pulse when wr_cnt = BUF_DEPTH is not written and sets the overflow flag; the frame is dropped at rx_over.
- Busy discard:
  - Any rx_pulse while busy sets the discard flag.
  - The next rx_over clears the flag and increments frame_drop_cnt.
  - While the flag is set, no capture starts, even if the drain has finished. This prevents mid-frame starts.
  - rx_over while busy with no preceding byte: ignored.
- States, one-hot: IDLE, CAPTURE, HDR_H, HDR_L, RD, WR, DONE.
  - DRAIN begins at HDR_H if the header is enabled, else at RD.
  - HDR_H/HDR_L: when wrfifo_full=0, wrfifo_req=1 with len[15:8], then len[7:0].
  - RD: drives rd_addr = rd_cnt to the buffer RAM (1-cycle synchronous read).
  - WR: waits while wrfifo_full=1, holding the data. When not full, pulses wrfifo_req with the RAM byte and increments rd_cnt.
    - If rd_cnt+1 = len, go to DONE; else go to RD.
  - Throughput: 1 byte per 2 clocks.
  - DONE: one cycle; clears counters, then IDLE.
- wrfifo_full is sampled registered. wrfifo_req is never asserted in a cycle following full=1 at the previous edge.
- frame_drop_cnt saturates at 16'hFFFF.
- wrfifo_data holds its last value when wrfifo_req=0.

Optional Feature:
- Macro: ETH_RX_LEN_HDR_EN.
- Defined: each frame is prefixed by a 2-byte big-endian length (HDR_H, HDR_L), giving len+2 wrfifo_req pulses.
- Undefined: HDR states are removed; DRAIN starts at RD and only the payload is written.

Decomposition:
- Package usb_eth_pkg: state one-hot localparams, LEN_HDR_BYTES=2, DROP_CNT_W=16.
- Sub-module: eth_rx_frame_buf, a simple dual-port RAM.
  - BUF_DEPTH×8, one write port, one registered read port, 1-cycle read latency.
  - Shared with future buffering blocks.

Test Plan:
- Header enabled; frame bytes 11,22,33,44 + rx_over → wrfifo sequence 00,04,11,22,33,44 (6 reqs); busy drops after DONE; drop_cnt=0.
- Same frame with wrfifo_full held 1 for 10 cycles after byte 22 → zero reqs during hold; resumes with 33,44; order intact, no duplicates.
- Second 3-byte frame arriving during drain of the first → first output intact; second yields no reqs; frame_drop_cnt=1. A third frame after idle is captured normally.
- BUF_DEPTH=2048; 2049-byte frame → zero reqs; frame_drop_cnt=1. A 2048-byte frame → header 08,00 plus 2048 bytes.
- rx_over alone → no reqs, no drop. rx_pulse(AB) coincident with rx_over → 00,01,AB.
- rst_n low for one clk mid-drain (after 2 payload bytes) → outputs 0 at next edge, state IDLE; a following 1-byte frame drains correctly.
